fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and PC sequencing stage, directly upstream of the decoder. It holds the program counter and fetches one instruction word from instruction memory. It presents the word to the decoder with a one-cycle `ID` strobe. After the decoder and ALU have resolved the instruction, it computes the next PC from the decoder's `Pc_cmd`/`Pc_val`/`Iv` outputs. Execution is non-pipelined: one instruction in flight at a time.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk` in 1, sole clock, rising edge
- `reset` in 1, synchronous, active-high
- `i_address` out 32, instruction memory byte address (= PC)
- `i_read_req` out 1, instruction read request, held until accepted
- `i_ready` in 1, memory returns valid `i_data_in` this cycle
- `i_data_in` in 32, instruction word from memory
- `instr` out 32, latched instruction, drives decoder `i_data_read`
- `ID` out 1, one-cycle strobe: `instr` valid for decode
- `pc_cmd` in 2, from decoder `Pc_cmd`
- `pc_val` in 2, from decoder `Pc_val`
- `iv` in 32, from decoder `Iv` (signed byte offset or absolute)
- `rs1_val` in 32, register-file value of `Rs1` (jump-register target)
- `cond` in 1, ALU branch result (1 = taken) for conditional branches
- `stall` in 1, holds the block in UPDATE while high
- `link_pc` out 32, PC+4 of current instruction, for JAL/JALR writeback
- `misalign` out 1, sticky misaligned-target flag (see Configuration)

## Operation
- FSM states:
  - FETCH: `i_read_req`=1, `i_address`=pc; go to WAIT.
  - WAIT: `i_read_req`=1 until `i_ready`; on `i_ready`, `instr` ← `i_data_in`, go to DECODE.
  - DECODE: `ID`=1 for this cycle only; decoder registers its outputs; go to EXEC.
  - EXEC: decoder outputs stable, ALU produces `cond`; go to UPDATE.
  - UPDATE: pc ← next_pc; go to FETCH if `stall`=0, else stay with pc unchanged.
  - HALT: only entered with the alignment check enabled.
- next_pc (computed in UPDATE):
  - `pc_cmd`=00 or 01: pc+4.
  - `pc_cmd`=10, `pc_val`=01 (unconditional): pc+4+`iv`.
  - `pc_cmd`=10, other `pc_val`: pc+4+`iv` if `cond`, else pc+4.
  - `pc_cmd`=11: `rs1_val`.
- All arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. Negative `iv` wraps correctly.
- `link_pc` ← pc+4 on entry to DECODE. It holds until the next DECODE.
- `i_ready` is ignored outside WAIT. `pc_cmd`, `pc_val`, `iv`, `rs1_val` and `cond` are sampled only in UPDATE.

## Timing
- Reset values: pc=`RESET_PC`, `i_address`=`RESET_PC`, `i_read_req`=0, `ID`=0, `instr`=0, `link_pc`=0, `misalign`=0, state=FETCH.
- First edge after reset deasserts: `i_read_req`=1.
- Per-instruction latency is 5 cycles with `i_ready` high in the first WAIT cycle, plus 1 cycle per extra wait cycle and per stalled UPDATE cycle.
- `i_address` changes only on the edge leaving UPDATE. It is stable throughout FETCH/WAIT.
- `instr` is stable from DECODE through UPDATE.
- Reset in any state wins on the same edge. An outstanding request is abandoned and `i_read_req` is 0 after that edge.
- `stall` and `i_ready` asserted together are independent: `stall` only has effect in UPDATE.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A next_pc with bits[1:0]≠0 sets `misalign`=1.
  - pc is not updated and the FSM enters HALT: no requests, `ID`=0.
  - Only reset exits HALT.
- Undefined:
  - next_pc bits[1:0] are forced to 0 and execution continues.
  - `misalign` is tied 0 and the HALT state does not exist.

## Structure
- Shared package `dlx_pkg` holds:
  - the `pc_cmd_t` encodings (PC_SEQ=2'b00, PC_REL=2'b10, PC_REG=2'b11) and PC_VAL_UNCOND=2'b01;
  - the fetch state enum;
  - the INSTR_BYTES=4 constant.
- One combinational sub-module, `next_pc_calc` (inputs pc, `pc_cmd`, `pc_val`, `iv`, `cond`, `rs1_val`; output next_pc), shared with a future pipelined fetch.

## Test plan
- **Reset release:** `RESET_PC`=0x100, `i_ready` tied 1 → `i_address`=0x100, `i_read_req`=1 the cycle after reset, `ID` pulse 2 cycles later, next `i_address`=0x104 five cycles after the first.
- **Memory wait:** `i_ready` low for 3 WAIT cycles → `i_read_req` and `i_address` held, `ID` delayed by exactly 3 cycles, `instr` = word present with `i_ready`.
- **Branches:** pc=0x200, `pc_cmd`=10, `iv`=0xFFFF_FFF0:
  - `cond`=1 → next 0x1F4;
  - `cond`=0 → 0x204;
  - `pc_val`=01 with `cond`=0 → 0x1F4.
- **Jump register and link:** `pc_cmd`=11, `rs1_val`=0x0000_4000 → next `i_address`=0x4000; `link_pc`=old pc+4.
- **Wrap-around and stall:**
  - pc=0xFFFF_FFFC, `pc_cmd`=00 → next 0x0.
  - `stall` high 2 cycles in UPDATE → FETCH delayed 2 cycles.
- **Misalign and mid-wait reset:**
  - `rs1_val`=0x4002: with `FETCH_ALIGN_CHECK_EN` → `misalign`=1, no further `i_read_req`; without it → next address 0x4000.
  - Reset asserted in WAIT → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/dlx_pkg.sv
// dlx_pkg: shared definitions for the DLX fetch path.
//   pc_cmd_t       - decoder Pc_cmd encodings (PC_SEQ, PC_REL, PC_REG)
//   PC_VAL_UNCOND  - Pc_val code for an unconditional relative branch
//   INSTR_BYTES    - size of one instruction word in bytes
//   fetch_state_t  - fetch FSM state encoding
package dlx_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_REL = 2'b10,
        PC_REG = 2'b11
    } pc_cmd_t;

    localparam logic [1:0]  PC_VAL_UNCOND = 2'b01;
    localparam logic [31:0] INSTR_BYTES   = 32'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection.
// Ports:
//   pc       in  32  current program counter
//   pc_cmd   in  2   decoder Pc_cmd
//   pc_val   in  2   decoder Pc_val (branch kind)
//   iv       in  32  signed byte offset (relative) from decoder
//   cond     in  1   ALU branch outcome, 1 = taken
//   rs1_val  in  32  jump-register target
//   next_pc  out 32  raw next PC (no alignment handling here)
// All additions are modulo 2^32, so negative offsets and PC wrap-around
// fall out of the plain 32-bit adder.
module next_pc_calc
    import dlx_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_cmd,
    input  logic [1:0]  pc_val,
    input  logic [31:0] iv,
    input  logic        cond,
    input  logic [31:0] rs1_val,
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;

    assign seq_pc = pc + INSTR_BYTES;

    always_comb begin
        next_pc = seq_pc;
        case (pc_cmd)
            PC_REL: begin
                // Offset is relative to the following instruction.
                if (pc_val == PC_VAL_UNCOND || cond) begin
                    next_pc = seq_pc + iv;
                end
            end
            PC_REG:  next_pc = rs1_val;
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: non-pipelined instruction fetch and PC sequencing.
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   - a misaligned next PC sets sticky misalign and halts until reset
//   undefined - next PC low bits are cleared, misalign tied 0, no HALT state
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_address/i_read_req/i_ready/i_data_in   instruction memory port
//   instr, ID           latched instruction word and its one-cycle decode strobe
//   pc_cmd/pc_val/iv/rs1_val/cond            next-PC controls, sampled in UPDATE
//   stall               holds the FSM in UPDATE
//   link_pc             PC+4 of the instruction being executed
//   misalign            sticky misaligned-target flag
//   state_dbg           current FSM state
// Memory handshake: i_read_req is raised on entry to WAIT and held with a
// stable i_address until the cycle i_ready is high; that cycle transfers
// i_data_in. i_ready in any other state has no effect.
module fetch_unit
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  i_address,
    output logic         i_read_req,
    input  logic         i_ready,
    input  logic [31:0]  i_data_in,
    output logic [31:0]  instr,
    output logic         ID,
    input  logic [1:0]   pc_cmd,
    input  logic [1:0]   pc_val,
    input  logic [31:0]  iv,
    input  logic [31:0]  rs1_val,
    input  logic         cond,
    input  logic         stall,
    output logic [31:0]  link_pc,
    output logic         misalign,
    output fetch_state_t state_dbg
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         id_q, id_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  link_q, link_d;
    logic [31:0]  calc_pc;

    next_pc_calc u_next_pc_calc (
        .pc      (pc_q),
        .pc_cmd  (pc_cmd),
        .pc_val  (pc_val),
        .iv      (iv),
        .cond    (cond),
        .rs1_val (rs1_val),
        .next_pc (calc_pc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        id_d    = 1'b0;
        instr_d = instr_q;
        link_d  = link_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_FETCH: begin
                req_d   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_ready) begin
                    req_d   = 1'b0;
                    instr_d = i_data_in;
                    link_d  = pc_q + INSTR_BYTES;
                    id_d    = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_UPDATE;
            ST_UPDATE: begin
`ifdef FETCH_ALIGN_CHECK_EN
                // A bad target freezes the PC at the offending instruction.
                if (calc_pc[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                    state_d    = ST_HALT;
                end else if (!stall) begin
                    pc_d    = calc_pc;
                    state_d = ST_FETCH;
                end
`else
                if (!stall) begin
                    pc_d    = {calc_pc[31:2], 2'b00};
                    state_d = ST_FETCH;
                end
`endif
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            id_q    <= 1'b0;
            instr_q <= 32'h0;
            link_q  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            id_q    <= id_d;
            instr_q <= instr_d;
            link_q  <= link_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign i_address  = pc_q;
    assign i_read_req = req_q;
    assign instr      = instr_q;
    assign ID         = id_q;
    assign link_pc    = link_q;
    assign state_dbg  = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign   = misalign_q;
`else
    assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import dlx_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  i_address;
    logic         i_read_req;
    logic         i_ready = 1'b0;
    logic [31:0]  i_data_in = 32'h0;
    logic [31:0]  instr;
    logic         ID;
    logic [1:0]   pc_cmd = 2'b00;
    logic [1:0]   pc_val = 2'b00;
    logic [31:0]  iv = 32'h0;
    logic [31:0]  rs1_val = 32'h0;
    logic         cond = 1'b0;
    logic         stall = 1'b0;
    logic [31:0]  link_pc;
    logic         misalign;
    fetch_state_t state_dbg;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_address  (i_address),
        .i_read_req (i_read_req),
        .i_ready    (i_ready),
        .i_data_in  (i_data_in),
        .instr      (instr),
        .ID         (ID),
        .pc_cmd     (pc_cmd),
        .pc_val     (pc_val),
        .iv         (iv),
        .rs1_val    (rs1_val),
        .cond       (cond),
        .stall      (stall),
        .link_pc    (link_pc),
        .misalign   (misalign),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference next-PC rule set, written straight from the sequencing rules.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] cmd,
                                             input logic [1:0] val, input logic [31:0] off,
                                             input logic c, input logic [31:0] tgt);
        logic [31:0] r;
        if (cmd == 2'b11)                            r = tgt;
        else if (cmd == 2'b10 && (val == 2'b01 || c)) r = pc + 32'd4 + off;
        else                                         r = pc + 32'd4;
        return {r[31:2], 2'b00};
    endfunction

    // Period bookkeeping: cycles between successive request rises.
    logic have_prev = 1'b0;
    int   prev_cyc  = 0;
    int   prev_per  = 0;

    // ---------------- driver ----------------
    // Serves one instruction: waits for the request, checks the address,
    // inserts w wait cycles, returns data, checks decode/link, then holds
    // stall for s UPDATE cycles. Returns on the last UPDATE negedge.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data,
                         input logic [1:0] cmd, input logic [1:0] val,
                         input logic [31:0] off, input logic [31:0] tgt,
                         input logic c, input int w, input int s);
        int n = 0;
        while (!i_read_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", i_read_req, 1'b1);
        check("fetch_addr", i_address, exp_addr);
        if (have_prev) check("period", 32'(cyc - prev_cyc), 32'(prev_per));
        have_prev = 1'b1;
        prev_cyc  = cyc;
        prev_per  = 5 + w + s;
        pc_cmd = cmd; pc_val = val; iv = off; rs1_val = tgt; cond = c;
        for (int k = 0; k < w; k++) begin
            i_ready   = 1'b0;
            i_data_in = $urandom;
            check("wait_req_held", {i_read_req, i_address}, {1'b1, exp_addr});
            @(negedge clk);
        end
        i_ready   = 1'b1;
        i_data_in = data;
        @(negedge clk);
        check("id_strobe", ID, 1'b1);
        check("id_delay", 32'(cyc - prev_cyc), 32'(w + 1));
        check("instr", instr, data);
        check("link_pc", link_pc, exp_addr + 32'd4);
        i_ready   = 1'($urandom_range(0, 1));
        i_data_in = $urandom;
        stall     = (s > 0);
        @(negedge clk);
        check("id_one_cycle", ID, 1'b0);
        @(negedge clk);
        check("instr_stable", instr, data);
        for (int k = 0; k < s; k++) begin
            check("stall_hold", {i_read_req, i_address}, {1'b0, exp_addr});
            @(negedge clk);
        end
        stall = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]  cmd;
        logic [1:0]  val;
        logic [31:0] off;
        logic [31:0] tgt;
        logic        c;
        int          w;
        int          s;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] pc_m;
    logic [1:0]  r_cmd, r_val;
    logic [31:0] r_off, r_tgt;
    logic        r_c;
    int          r_w, r_s, cnt;

    initial begin
        vecs[0] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 0, 0, 32'h0000_0104};
        vecs[1] = '{2'b11, 2'b00, 32'h0,         32'h0000_0200, 1'b0, 3, 0, 32'h0000_0200};
        vecs[2] = '{2'b10, 2'b00, 32'hFFFF_FFF0, 32'h0,         1'b1, 0, 0, 32'h0000_01F4};
        vecs[3] = '{2'b11, 2'b00, 32'h0,         32'h0000_0200, 1'b0, 1, 0, 32'h0000_0200};
        vecs[4] = '{2'b10, 2'b00, 32'hFFFF_FFF0, 32'h0,         1'b0, 0, 0, 32'h0000_0204};
        vecs[5] = '{2'b11, 2'b00, 32'h0,         32'h0000_0200, 1'b0, 0, 2, 32'h0000_0200};
        vecs[6] = '{2'b10, 2'b01, 32'hFFFF_FFF0, 32'h0,         1'b0, 2, 1, 32'h0000_01F4};
        vecs[7] = '{2'b11, 2'b00, 32'h0,         32'h0000_4000, 1'b0, 0, 0, 32'h0000_4000};
        vecs[8] = '{2'b11, 2'b00, 32'h0,         32'hFFFF_FFFC, 1'b0, 0, 0, 32'hFFFF_FFFC};
        vecs[9] = '{2'b00, 2'b00, 32'h0,         32'h0,         1'b0, 0, 0, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", i_address, RST_PC);
        check("rst_req", i_read_req, 1'b0);
        check("rst_id", ID, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_link", link_pc, 32'h0);
        check("rst_misalign", misalign, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("req_after_reset", i_read_req, 1'b1);

        // Table-driven directed sequence
        pc_m = RST_PC;
        for (int i = 0; i < 10; i++) begin
            serve(pc_m, $urandom, vecs[i].cmd, vecs[i].val, vecs[i].off, vecs[i].tgt,
                  vecs[i].c, vecs[i].w, vecs[i].s);
            pc_m = vecs[i].exp_next;
        end

        // Randomized instructions against the reference rules
        for (int i = 0; i < 24; i++) begin
            r_cmd = 2'($urandom_range(0, 3));
            r_val = 2'($urandom_range(0, 3));
            r_off = $urandom;
            if ($urandom_range(0, 1) == 1) r_off = {{20{r_off[11]}}, r_off[11:0]};
            r_tgt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            r_off = {r_off[31:2], 2'b00};
            r_tgt = {r_tgt[31:2], 2'b00};
`endif
            r_c = 1'($urandom_range(0, 1));
            r_w = $urandom_range(0, 3);
            r_s = $urandom_range(0, 2);
            serve(pc_m, $urandom, r_cmd, r_val, r_off, r_tgt, r_c, r_w, r_s);
            pc_m = ref_next(pc_m, r_cmd, r_val, r_off, r_c, r_tgt);
        end

        // Misaligned jump-register target
        serve(pc_m, $urandom, 2'b11, 2'b00, 32'h0, 32'h0000_4002, 1'b0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        @(negedge clk);
        check("misalign_set", misalign, 1'b1);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (i_read_req || ID) cnt++;
        end
        check("halt_no_req", 32'(cnt), 32'h0);
        check("halt_pc_held", i_address, pc_m);
`else
        cnt = 0;
        while (!i_read_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("align_addr", {i_read_req, i_address}, {1'b1, 32'h0000_4000});
        check("misalign_tied", misalign, 1'b0);
`endif

        // Reset while a request is outstanding, with i_ready high on that edge
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("req_before_midreset", i_read_req, 1'b1);
        i_ready   = 1'b1;
        i_data_in = 32'hDEAD_BEEF;
        reset     = 1'b1;
        @(negedge clk);
        check("mr_addr", i_address, RST_PC);
        check("mr_req", i_read_req, 1'b0);
        check("mr_id", ID, 1'b0);
        check("mr_instr", instr, 32'h0);
        check("mr_link", link_pc, 32'h0);
        check("mr_misalign", misalign, 1'b0);
        reset     = 1'b0;
        i_ready   = 1'b0;
        have_prev = 1'b0;
        serve(RST_PC, 32'h1234_5678, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1, 0);
        serve(RST_PC + 32'd4, 32'h0BAD_F00D, 2'b10, 2'b01, 32'h8, 32'h0, 1'b0, 0, 0);
        serve(32'h0000_0110, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
